// File: rtl/sum_sequence_arbiter.sv
// Round-robin shared accumulator: grants one requester, then runs sum = a + b + c
// over three cycles and pulses done on the owner's bit.
//
// state  | meaning
// IDLE   | sample req, arbitrate, register grant
// LOAD   | sum <= op_a of owner
// ADD_B  | sum <= sum + op_b of owner
// ADD_C  | sum <= sum + op_c of owner, raise done/sum_valid
// DONE   | drop done, sum_valid and grant
module sum_sequence_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] op_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] op_c,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         sum,
    output logic                          sum_valid
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, LOAD, ADD_B, ADD_C, DONE} state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         rr_last, rr_nxt;
    logic [NUM_REQ-1:0]    grant_nxt, done_nxt;
    logic [DATA_WIDTH-1:0] sum_nxt;
    logic                  valid_nxt, busy_nxt;
    logic                  found;
    logic [IW-1:0]         pick_idx;
    logic [IW-1:0]         cand;

    // rr_last doubles as the owner index once a grant is issued
    logic [DATA_WIDTH-1:0] sel_a, sel_b, sel_c;
    assign sel_a = op_a[rr_last*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b = op_b[rr_last*DATA_WIDTH +: DATA_WIDTH];
    assign sel_c = op_c[rr_last*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(rr_last) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_last;
        grant_nxt = grant;
        done_nxt  = '0;
        valid_nxt = 1'b0;
        sum_nxt   = sum;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = NUM_REQ'(1) << pick_idx;
                    rr_nxt    = pick_idx;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sum_nxt   = sel_a;
                state_nxt = ADD_B;
            end
            ADD_B: begin
                sum_nxt   = sum + sel_b;
                state_nxt = ADD_C;
            end
            ADD_C: begin
                sum_nxt   = sum + sel_c;
                done_nxt  = grant;
                valid_nxt = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_last   <= IW'(NUM_REQ - 1);
            grant     <= '0;
            done      <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_last   <= rr_nxt;
            grant     <= grant_nxt;
            done      <= done_nxt;
            sum       <= sum_nxt;
            sum_valid <= valid_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_sum_sequence_arbiter.sv
// Directed bench for sum_sequence_arbiter: a vector table of single-requester
// transactions plus hand-written multi-requester and reset sequences.
module tb_sum_sequence_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   op_a, op_b, op_c;
    logic [N-1:0]     grant, done;
    logic             busy, sum_valid;
    logic [W-1:0]     sum;

    int checks   = 0;
    int failures = 0;

    sum_sequence_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .sum_valid (sum_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] exp_sum;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c);
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
        op_c[i*W +: W] = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Caller is positioned just after an edge; the next edge must be the IDLE sample (E0).
    // drop_mode: 0 keep req, 1 drop on done, 2 drop while in ADD_B.
    task automatic run_txn(input int idx, input logic [15:0] exp_sum, input int drop_mode);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        @(posedge clk); #1;
        chk("grant_e0", 32'(grant), 32'(oh));
        chk("busy_e0", 32'(busy), 32'd1);
        chk("done_e0", 32'(done), 32'd0);
        @(posedge clk); #1;
        if (drop_mode == 2) req[idx] = 1'b0;
        @(posedge clk); #1;
        chk("grant_stable", 32'(grant), 32'(oh));
        chk("done_early", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("done_e3", 32'(done), 32'(oh));
        chk("valid_e3", 32'(sum_valid), 32'd1);
        chk("sum_e3", 32'(sum), 32'(exp_sum));
        if (drop_mode == 1) req[idx] = 1'b0;
        @(posedge clk); #1;
        chk("grant_e4", 32'(grant), 32'd0);
        chk("done_e4", 32'(done), 32'd0);
        chk("valid_e4", 32'(sum_valid), 32'd0);
        chk("busy_e4", 32'(busy), 32'd0);
        chk("sum_hold", 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 16'd3,     16'd4,     16'd5,     16'd12};
        vecs[1] = '{0, 16'hFFFF,  16'h0002,  16'h0001,  16'h0002};
        vecs[2] = '{3, 16'h1000,  16'h2000,  16'h3000,  16'h6000};
        vecs[3] = '{2, 16'h8000,  16'h8000,  16'h0001,  16'h0001};
        vecs[4] = '{1, 16'h0000,  16'h0000,  16'h0000,  16'h0000};
        vecs[5] = '{2, 16'h1234,  16'h1111,  16'h0001,  16'h2346};

        reset = 1'b1;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        op_c  = '0;
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_valid", 32'(sum_valid), 32'd0);
        do_reset();

        // Single-requester vectors, including modulo wrap cases
        foreach (vecs[k]) begin
            op_a = '0; op_b = '0; op_c = '0;
            set_ops(vecs[k].idx, vecs[k].a, vecs[k].b, vecs[k].c);
            req = '0;
            req[vecs[k].idx] = 1'b1;
            run_txn(vecs[k].idx, vecs[k].exp_sum, 1);
        end

        // All four requesting: round-robin order 0,1,2,3 with 5-cycle spacing
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 16'(i + 1), 16'd10, 16'd100);
        req = 4'b1111;
        for (int i = 0; i < N; i++) run_txn(i, 16'(111 + i), 1);
        @(posedge clk); #1;
        chk("idle_after_rr", 32'(grant), 32'd0);

        // Reset asserted while in ADD_B
        do_reset();
        op_a = '0; op_b = '0; op_c = '0;
        set_ops(0, 16'd5, 16'd6, 16'd7);
        req = 4'b0001;
        @(posedge clk); #1;
        chk("r4_grant", 32'(grant), 32'd1);
        @(posedge clk); #1;
        chk("r4_sum_a", 32'(sum), 32'd5);
        #2 reset = 1'b1;
        #1;
        chk("r4_async_grant", 32'(grant), 32'd0);
        chk("r4_async_busy", 32'(busy), 32'd0);
        chk("r4_async_sum", 32'(sum), 32'd0);
        @(posedge clk); #1;
        chk("r4_no_done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_ops(i, 16'(i + 20), 16'd1, 16'd1);
        req = 4'b1111;
        run_txn(0, 16'd22, 1);
        req = '0;
        @(posedge clk); #1;

        // req[2] dropped mid-sequence: still completes
        op_a = '0; op_b = '0; op_c = '0;
        set_ops(2, 16'd100, 16'd200, 16'd300);
        req = 4'b0100;
        run_txn(2, 16'd600, 2);

        // req[0] held forever alongside req[2]: grants alternate
        do_reset();
        op_a = '0; op_b = '0; op_c = '0;
        set_ops(0, 16'd1, 16'd2, 16'd3);
        set_ops(2, 16'd7, 16'd8, 16'd9);
        req = 4'b0101;
        run_txn(0, 16'd6, 0);
        run_txn(2, 16'd24, 0);
        run_txn(0, 16'd6, 0);
        run_txn(2, 16'd24, 0);
        req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
